// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: signal bundle between the multicycle controller and the datapath/memories.
// Parameters: OP_W, FUNC_W, ALUOP_W (must match the controller instance).
// master modport: controller side (samples op/func/imem_ready/dmem_ready, drives controls and trap status)
// slave modport:  datapath side (drives op/func/readies, samples controls and trap status)
interface mc_ctrl_fsm_if #(
    parameter int OP_W    = 4,
    parameter int FUNC_W  = 4,
    parameter int ALUOP_W = 3
);
    logic [OP_W-1:0]    op;
    logic [FUNC_W-1:0]  func;
    logic               imem_ready;
    logic               dmem_ready;
    logic [1:0]         ALUSrc1;
    logic [1:0]         ALUSrc2;
    logic [ALUOP_W-1:0] ALUop;
    logic               IntMemRead;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               FlagSel;
    logic               IRWrite;
    logic               PCSrc;
    logic               RegRead;
    logic               MemtoReg;
    logic               ExOp;
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               trap;
    logic [1:0]         trap_cause;
    logic               halted;

    modport master (
        input  op, func, imem_ready, dmem_ready,
        output ALUSrc1, ALUSrc2, ALUop, IntMemRead, PCWrite, PCWriteCond, FlagSel, IRWrite,
               PCSrc, RegRead, MemtoReg, ExOp, RegWrite, MemRead, MemWrite, trap, trap_cause, halted
    );

    modport slave (
        output op, func, imem_ready, dmem_ready,
        input  ALUSrc1, ALUSrc2, ALUop, IntMemRead, PCWrite, PCWriteCond, FlagSel, IRWrite,
               PCSrc, RegRead, MemtoReg, ExOp, RegWrite, MemRead, MemWrite, trap, trap_cause, halted
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control unit for the 4-bit-opcode datapath.
// Ports: clk (rising edge), rst (asynchronous, active-low),
//        bus (mc_ctrl_fsm_if.master): op/func from IR, imem_ready/dmem_ready handshakes,
//        datapath controls, trap pulse, sticky trap_cause (01 illegal, 10 timeout), halted.
// Parameters: OP_W, FUNC_W, ALUOP_W widths; WAIT_MAX stall-cycle limit per handshake (0 = unlimited).
// Optional feature: define MC_CTRL_HALT_EN to decode op 0000 / func 0000 as HALT.
module mc_ctrl_fsm #(
    parameter int OP_W     = 4,
    parameter int FUNC_W   = 4,
    parameter int ALUOP_W  = 3,
    parameter int WAIT_MAX = 15
) (
    input logic           clk,
    input logic           rst,
    mc_ctrl_fsm_if.master bus
);
    localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [3:0] S_IF      = 4'd0;
    localparam logic [3:0] S_ID      = 4'd1;
    localparam logic [3:0] S_EX_ALU  = 4'd2;
    localparam logic [3:0] S_EX_BR   = 4'd3;
    localparam logic [3:0] S_EX_JMP  = 4'd4;
    localparam logic [3:0] S_EX_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_LD  = 4'd6;
    localparam logic [3:0] S_MEM_ST  = 4'd7;
    localparam logic [3:0] S_WB_LD   = 4'd8;
    localparam logic [3:0] S_TRAP    = 4'd9;
    localparam logic [3:0] S_HALT    = 4'd10;

    logic [3:0]       state, next, id_next, halt_sel;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       dec_op;
    logic [1:0]       dec_func;
    logic [1:0]       cause;
    logic             op_ok, func_ok, waiting, ready, timeout, ext;
    logic [2:0]       alu_code;
    logic [1:0]       src1, src2;

    // Opcode/func bits above the 4-bit field must be zero to be legal.
    assign op_ok   = (bus.op >> 4) == '0;
    assign func_ok = (bus.func >> 4) == '0;

`ifdef MC_CTRL_HALT_EN
    assign halt_sel   = (func_ok && bus.func[3:0] == 4'd0) ? S_HALT : S_TRAP;
    assign bus.halted = state == S_HALT;
`else
    assign halt_sel   = S_TRAP;
    assign bus.halted = 1'b0;
`endif

    always_comb begin
        id_next = S_EX_ALU;
        case (bus.op[3:0])
            4'b0000:          id_next = (func_ok && bus.func[3:0] inside {4'd1, 4'd2, 4'd3}) ? S_EX_ALU : halt_sel;
            4'b0001, 4'b0010: id_next = S_EX_ADDR;
            4'b0011:          id_next = S_EX_JMP;
            4'b0100, 4'b0101: id_next = S_EX_BR;
            default:          id_next = S_EX_ALU;
        endcase
        if (!op_ok) id_next = S_TRAP;
    end

    // Only IF, MEM_LD and MEM_ST wait on a handshake; the counter restarts on every state change.
    assign waiting = state == S_IF || state == S_MEM_LD || state == S_MEM_ST;
    assign ready   = (state == S_IF) ? bus.imem_ready : bus.dmem_ready;
    assign timeout = (WAIT_MAX != 0) && cnt == CNT_W'(WAIT_MAX) && !ready;

    always_comb begin
        next = S_IF;
        case (state)
            S_IF:      next = bus.imem_ready ? S_ID : timeout ? S_TRAP : S_IF;
            S_ID:      next = id_next;
            S_EX_ADDR: next = (dec_op == 4'b0001) ? S_MEM_LD : S_MEM_ST;
            S_MEM_LD:  next = bus.dmem_ready ? S_WB_LD : timeout ? S_TRAP : S_MEM_LD;
            S_MEM_ST:  next = bus.dmem_ready ? S_IF : timeout ? S_TRAP : S_MEM_ST;
            S_HALT:    next = S_HALT;
            default:   next = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IF;
            cnt      <= '0;
            dec_op   <= '0;
            dec_func <= '0;
            cause    <= 2'b00;
        end else begin
            state <= next;
            cnt   <= (waiting && next == state) ? cnt + 1'b1 : '0;
            if (state == S_ID) begin
                dec_op   <= bus.op[3:0];
                dec_func <= bus.func[1:0];
            end
            // Traps out of ID are decode faults; all others are handshake timeouts.
            if (next == S_TRAP) cause <= (state == S_ID) ? 2'b01 : 2'b10;
        end
    end

    // EX_ALU controls from the latched opcode; shifts map func 1..3 onto ALU codes 2..4.
    always_comb begin
        alu_code = 3'd0;
        src1     = 2'b01;
        src2     = 2'b00;
        case (dec_op)
            4'b0000:                   alu_code = {1'b0, dec_func} + 3'd1;
            4'b1100, 4'b1101, 4'b1110: alu_code = 3'd1;
            4'b1011, 4'b0111:          alu_code = 3'd5;
            4'b1111, 4'b0110:          alu_code = 3'd6;
            default:                   alu_code = 3'd0;
        endcase
        if (dec_op == 4'b0000) src1 = 2'b10;
        if (dec_op inside {4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0111, 4'b0110}) begin
            src1 = 2'b10;
            src2 = 2'b10;
        end
    end

    assign ext            = dec_op == 4'b1010 || dec_op == 4'b1110;
    assign bus.trap_cause = cause;

    always_comb begin
        bus.ALUSrc1     = 2'b00;
        bus.ALUSrc2     = 2'b00;
        bus.ALUop       = '0;
        bus.IntMemRead  = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.FlagSel     = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.RegRead     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.ExOp        = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.trap        = 1'b0;
        case (state)
            S_IF: begin
                bus.IntMemRead = 1'b1;
                bus.ALUSrc2    = 2'b01;
                bus.PCWrite    = bus.imem_ready;
                bus.IRWrite    = bus.imem_ready;
            end
            S_ID: bus.RegRead = 1'b1;
            S_EX_ALU: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                bus.ALUSrc1  = src1;
                bus.ALUSrc2  = src2;
                bus.ALUop    = ALUOP_W'(alu_code);
                bus.ExOp     = ext;
            end
            S_EX_BR: begin
                bus.PCSrc       = 1'b1;
                bus.PCWriteCond = 1'b1;
                bus.ALUSrc1     = 2'b01;
                bus.ALUop       = ALUOP_W'(3'd1);
                bus.FlagSel     = dec_op[0];
            end
            S_EX_JMP: begin
                bus.PCWrite = 1'b1;
                bus.ALUSrc2 = 2'b11;
            end
            S_EX_ADDR: begin
                bus.ALUSrc1 = 2'b01;
                bus.ALUSrc2 = 2'b10;
            end
            S_MEM_LD: bus.MemRead  = 1'b1;
            S_MEM_ST: bus.MemWrite = 1'b1;
            S_WB_LD:  bus.RegWrite = 1'b1;
            S_TRAP:   bus.trap     = 1'b1;
            default:  ;
        endcase
    end
endmodule
